// File: rtl/proj_fm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proj_fm_pkg
// Description : Width helper and derived-size functions for the feature-map RAM
// Revision    : 1.0 - initial release
// ============================================================================
package proj_fm_pkg;

    // Index width for a range of v values; never narrower than one bit
    function automatic int width_of(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int fm_words(input int rams, input int entries, input int offset);
        return rams * entries * offset;
    endfunction

    function automatic int fm_chunks(input int rams, input int entries, input int offset,
                                     input int chunk);
        return fm_words(rams, entries, offset) / chunk;
    endfunction

    function automatic int fm_depth(input int entries, input int offset);
        return entries * offset;
    endfunction

    function automatic int cnt_width(input int rams, input int entries, input int offset);
        return width_of(fm_words(rams, entries, offset));
    endfunction

    function automatic int chunk_width(input int rams, input int entries, input int offset,
                                       input int chunk);
        return width_of(fm_chunks(rams, entries, offset, chunk));
    endfunction

    function automatic int buf_width(input int buffers);
        return width_of(buffers);
    endfunction

    function automatic int addr_width(input int entries, input int offset);
        return width_of(fm_depth(entries, offset));
    endfunction

endpackage : proj_fm_pkg
`default_nettype wire

// File: rtl/proj_fm_bank.sv
`default_nettype none
// ============================================================================
// Module      : proj_fm_bank
// Description : Simple dual-port RAM, synchronous write, asynchronous read
// Revision    : 1.0 - initial release
// ============================================================================
module proj_fm_bank #(
    parameter int DEPTH     = 2,
    parameter int DATA_BITS = 8,
    parameter int ADDR_W    = 1
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : proj_fm_bank
`default_nettype wire

// File: rtl/proj_fm_ram.sv
`default_nettype none
// ============================================================================
// Module      : proj_fm_ram
// Description : Rotating multi-buffer staging RAM; one word in, one chunk out
// Revision    : 1.0 - initial release
// ============================================================================
module proj_fm_ram
    import proj_fm_pkg::*;
#(
    parameter int BUFFER_COUNT = 2,
    parameter int RAMS         = 2,
    parameter int ENTRIES      = 2,
    parameter int OFFSET       = 1,
    parameter int CHUNK_SIZE   = 2,
    parameter int DATA_BITS    = 8
) (
    input  logic                            in_clk,
    input  logic                            in_rst,
    input  logic [DATA_BITS-1:0]            in_wdata,
    output logic [CHUNK_SIZE*DATA_BITS-1:0] out_rdata
);

    localparam int c_n_words = fm_words(RAMS, ENTRIES, OFFSET);
    localparam int c_chunks  = fm_chunks(RAMS, ENTRIES, OFFSET, CHUNK_SIZE);
    localparam int c_depth   = fm_depth(ENTRIES, OFFSET);
    localparam int c_cnt_w   = cnt_width(RAMS, ENTRIES, OFFSET);
    localparam int c_chunk_w = chunk_width(RAMS, ENTRIES, OFFSET, CHUNK_SIZE);
    localparam int c_buf_w   = buf_width(BUFFER_COUNT);
    localparam int c_addr_w  = addr_width(ENTRIES, OFFSET);
    localparam int c_sel_w   = width_of(RAMS);

    logic [c_cnt_w-1:0]   r_wr_cnt;
    logic [c_chunk_w-1:0] r_rd_chunk;
    logic [c_buf_w-1:0]   r_wr_idx;
    logic [c_buf_w-1:0]   r_rd_idx;
    logic                 r_primed;

    logic                 w_swap;
    int                   w_rd_base;
    logic [c_sel_w-1:0]   w_wr_bank;
    logic [c_sel_w-1:0]   w_rd_bank0;
    logic [c_addr_w-1:0]  w_wr_addr;
    logic [c_addr_w-1:0]  w_rd_addr;
    logic [DATA_BITS-1:0] w_bank_rdata [BUFFER_COUNT][RAMS];
    logic [CHUNK_SIZE*DATA_BITS-1:0] w_chunk;

    assign w_swap = (r_wr_cnt == c_cnt_w'(c_n_words - 1));

    // Words are striped across banks, so a chunk is CHUNK_SIZE adjacent banks at one address
    always_comb begin
        w_rd_base  = int'(r_rd_chunk) * CHUNK_SIZE;
        w_wr_bank  = c_sel_w'(int'(r_wr_cnt) % RAMS);
        w_wr_addr  = c_addr_w'(int'(r_wr_cnt) / RAMS);
        w_rd_bank0 = c_sel_w'(w_rd_base % RAMS);
        w_rd_addr  = c_addr_w'(w_rd_base / RAMS);
    end

    always_comb begin
        w_chunk = '0;
        for (int j = 0; j < CHUNK_SIZE; j++) begin
            w_chunk[j*DATA_BITS +: DATA_BITS] =
                w_bank_rdata[r_rd_idx][c_sel_w'(int'(w_rd_bank0) + j)];
        end
    end

    for (genvar b = 0; b < BUFFER_COUNT; b++) begin : g_buf
        for (genvar r = 0; r < RAMS; r++) begin : g_bank
            logic w_we;

            assign w_we = !in_rst && (r_wr_idx == c_buf_w'(b)) && (w_wr_bank == c_sel_w'(r));

            proj_fm_bank #(
                .DEPTH     (c_depth),
                .DATA_BITS (DATA_BITS),
                .ADDR_W    (c_addr_w)
            ) u_bank (
                .clk     (in_clk),
                .i_we    (w_we),
                .i_waddr (w_wr_addr),
                .i_wdata (in_wdata),
                .i_raddr (w_rd_addr),
                .o_rdata (w_bank_rdata[b][r])
            );
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_wr_cnt   <= '0;
            r_rd_chunk <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_primed   <= 1'b0;
            out_rdata  <= '0;
        end else begin
            r_wr_cnt <= w_swap ? '0 : r_wr_cnt + 1'b1;

            // A completed buffer restarts the read stream, overriding the chunk advance
            if (w_swap) begin
                r_rd_idx   <= r_wr_idx;
                r_wr_idx   <= (r_wr_idx == c_buf_w'(BUFFER_COUNT - 1)) ? '0 : r_wr_idx + 1'b1;
                r_rd_chunk <= '0;
                r_primed   <= 1'b1;
            end else if (r_primed) begin
                r_rd_chunk <= (r_rd_chunk == c_chunk_w'(c_chunks - 1)) ? '0 : r_rd_chunk + 1'b1;
            end

            if (r_primed) begin
                out_rdata <= w_chunk;
            end
        end
    end

endmodule : proj_fm_ram
`default_nettype wire

// File: tb/tb_proj_fm_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_proj_fm_ram
// Description : Self-checking bench for proj_fm_ram, default and N=16 builds
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proj_fm_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wdata;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;

    typedef struct {
        logic        rst;
        logic [7:0]  wdata;
        logic [15:0] exp_a;
    } vec_t;

    typedef struct {
        int          dut;
        logic [15:0] exp;
        string       tag;
    } sb_t;

    sb_t sbq[$];
    int  n_cmp = 0;
    int  n_err = 0;

    vec_t tv1[14];
    vec_t tv3[9];

    always #5 clk = ~clk;

    proj_fm_ram dut_a (
        .in_clk   (clk),
        .in_rst   (rst),
        .in_wdata (wdata),
        .out_rdata(rdata_a)
    );

    proj_fm_ram #(
        .BUFFER_COUNT (2),
        .RAMS         (4),
        .ENTRIES      (2),
        .OFFSET       (2),
        .CHUNK_SIZE   (2),
        .DATA_BITS    (8)
    ) dut_b (
        .in_clk   (clk),
        .in_rst   (rst),
        .in_wdata (wdata),
        .out_rdata(rdata_b)
    );

    // Edge e (1-based after reset) writes word e-1; buffer q streams chunks 0..C-1 twice
    function automatic logic [15:0] exp_stream(input int e, input int n, input int c);
        int q;
        int k;
        logic [7:0] lo;
        logic [7:0] hi;
        if (e <= n) return 16'h0000;
        q  = (e - n - 1) / n;
        k  = (e - n - 1) % c;
        lo = 8'((n * q + 2 * k) % 256);
        hi = 8'((n * q + 2 * k + 1) % 256);
        return {hi, lo};
    endfunction

    task automatic step(input logic r, input logic [7:0] w, input logic [15:0] ea,
                        input logic [15:0] eb, input string tag);
        sb_t         s;
        logic [15:0] act;
        @(negedge clk);
        rst   = r;
        wdata = w;
        sbq.push_back('{0, ea, tag});
        sbq.push_back('{1, eb, tag});
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            s   = sbq.pop_front();
            act = (s.dut == 0) ? rdata_a : rdata_b;
            n_cmp++;
            if (act !== s.exp) begin
                n_err++;
                $display("FAIL %s dut%0d: got %h expected %h", s.tag, s.dut, act, s.exp);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        wdata = 8'h00;

        tv1[0]  = '{1'b1, 8'h00, 16'h0000};
        tv1[1]  = '{1'b1, 8'h00, 16'h0000};
        tv1[2]  = '{1'b0, 8'h00, 16'h0000};
        tv1[3]  = '{1'b0, 8'h01, 16'h0000};
        tv1[4]  = '{1'b0, 8'h02, 16'h0000};
        tv1[5]  = '{1'b0, 8'h03, 16'h0000};
        tv1[6]  = '{1'b0, 8'h04, 16'h0100};
        tv1[7]  = '{1'b0, 8'h05, 16'h0302};
        tv1[8]  = '{1'b0, 8'h06, 16'h0100};
        tv1[9]  = '{1'b0, 8'h07, 16'h0302};
        tv1[10] = '{1'b0, 8'h08, 16'h0504};
        tv1[11] = '{1'b0, 8'h09, 16'h0706};
        tv1[12] = '{1'b0, 8'h0A, 16'h0504};
        tv1[13] = '{1'b0, 8'h0B, 16'h0706};

        tv3[0] = '{1'b1, 8'h55, 16'h0000};
        tv3[1] = '{1'b0, 8'hA0, 16'h0000};
        tv3[2] = '{1'b0, 8'hA1, 16'h0000};
        tv3[3] = '{1'b0, 8'hA2, 16'h0000};
        tv3[4] = '{1'b0, 8'hA3, 16'h0000};
        tv3[5] = '{1'b0, 8'hB0, 16'hA1A0};
        tv3[6] = '{1'b0, 8'hB1, 16'hA3A2};
        tv3[7] = '{1'b0, 8'hB2, 16'hA1A0};
        tv3[8] = '{1'b0, 8'hB3, 16'hA3A2};

        // Reset, first fill and first swap; the N=16 build stays silent throughout
        for (int i = 0; i < 14; i++) begin
            step(tv1[i].rst, tv1[i].wdata, tv1[i].exp_a, 16'h0000, "fill");
        end

        // Long continuous stream: buffer rotation and wrap on both builds
        step(1'b1, 8'h00, 16'h0000, 16'h0000, "reset2");
        for (int e = 1; e <= 82; e++) begin
            step(1'b0, 8'((e - 1) % 256), exp_stream(e, 4, 2), exp_stream(e, 16, 8), "stream");
        end

        // Reset two words into a period, then a fresh fill
        for (int i = 0; i < 9; i++) begin
            step(tv3[i].rst, tv3[i].wdata, tv3[i].exp_a, 16'h0000, "midrst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_proj_fm_ram
`default_nettype wire
